adc_serial_readout: RTL and testbench
=====================================

ADC_SERIAL_READOUT -- requirements
Module: adc_serial_readout

Interface
REQ-001 The block SHALL have parameter NCH, default 8: number of ADC serial channels, 1..16.
REQ-002 The block SHALL have parameter WIDTH, default 12: bits per conversion, 2..32.
REQ-003 The block SHALL have parameter CLKDIV, default 4: system clocks per tick, at least 1.
REQ-004 The block SHALL have parameter CONV_CYC, default 16: ADClk periods of conversion before shift-out, at least 1.
REQ-005 The block SHALL have port Clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-006 The block SHALL have port Rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port Start, input, 1 bit: request one frame; sampled only in IDLE.
REQ-008 The block SHALL have port Cont, input, 1 bit: continuous mode; checked at end of frame.
REQ-009 The block SHALL have port Mode, input, 2 bits: converter mode, latched at frame start.
REQ-010 The block SHALL have port ADMode, output, 2 bits: latched Mode driven to the converters.
REQ-011 The block SHALL have ports ADRst and ADClk, output, 1 bit each: converter reset and converter clock.
REQ-012 The block SHALL have port ADSout, input, NCH bits: one serial data bit per channel.
REQ-013 The block SHALL have ports ClkOut, DataOut and FrameOut, output, 1 bit each: serial output clock, data and frame-valid.
REQ-014 The block SHALL have ports Busy, Done and Overrun, output, 1 bit each: frame active, 1-cycle end-of-frame pulse, and sticky overrun flag.

Function
REQ-015 A tick SHALL occur when the divider counter reaches CLKDIV-1; the counter is cleared when ADRST is entered and holds at 0 in IDLE.
REQ-016 The state machine SHALL have states IDLE, ADRST, CONV, SHIFT and OUT; Busy SHALL be 1 in every state except IDLE.
REQ-017 In IDLE, with Start=1 at a rising Clk edge, the block SHALL latch Mode into ADMode, clear Overrun and enter ADRST, so ADRst=1 from the next cycle.
REQ-018 ADRST SHALL hold ADRst=1 and ADClk=0 for 2 ticks, then enter CONV.
REQ-019 CONV SHALL toggle ADClk on every tick for 2*CONV_CYC ticks, ending with ADClk=0, and SHALL capture no data.
REQ-020 SHIFT SHALL toggle ADClk on every tick for 2*WIDTH ticks.
REQ-021 In SHIFT, on each tick where ADClk is 1 before the toggle, ADSout[i] SHALL shift into the LSB of WIDTH-bit register i, so the first sample is the MSB.
REQ-022 OUT SHALL hold ADClk=0 and FrameOut=1.
REQ-023 OUT SHALL send NCH*WIDTH bits, channel 0 first and MSB first within each channel.
REQ-024 Each OUT bit SHALL take 2 ticks: in the first, DataOut takes the bit and ClkOut=0; in the second, ClkOut=1 and DataOut is unchanged.
REQ-025 After the last OUT tick, Done SHALL be 1 for exactly one cycle, and FrameOut and ClkOut SHALL return to 0.
REQ-026 If Cont=1 at that point, the next state SHALL be ADRST with ADMode re-latched from Mode; otherwise the next state SHALL be IDLE.
REQ-027 From Start sampled to Done asserted SHALL be 1+CLKDIV*(2+2*CONV_CYC+2*WIDTH+2*NCH*WIDTH) cycles.
REQ-028 Start=1 while Busy=1 SHALL set Overrun=1 and SHALL NOT change frame timing or data.
REQ-029 Overrun SHALL clear only on reset or on an accepted Start in IDLE.
REQ-030 Cont deasserted mid-frame SHALL let the current frame complete; Cont asserted in IDLE without Start SHALL have no effect.
REQ-031 When CLKDIV=1, a tick SHALL occur every cycle and all timing above SHALL hold.
REQ-032 Counters SHALL be sized with $clog2 of their maximum count, and no counter SHALL wrap inside a state.

Reset
REQ-033 While Rst=1, the block SHALL be in IDLE and every output SHALL be 0 (ADMode=2'b00), immediately and without waiting for Clk.
REQ-034 While Rst=1, the divider, bit counters and shift registers SHALL be cleared.
REQ-035 Reset asserted mid-frame SHALL abort the frame with no Done pulse.
REQ-036 The first Start SHALL be sampled on the first rising Clk edge after Rst falls.

Verification (NCH=2, WIDTH=4, CLKDIV=2, CONV_CYC=3)
REQ-037 Single frame: Start pulse at cycle 0, Mode=2'b10, ADSout[0] MSB-first 1,0,1,0 and ADSout[1] 0,1,1,0 -> ADMode=2'b10; DataOut on ClkOut rising edges = 1,0,1,0,0,1,1,0; Done=1 at cycle 65 only; Busy=0 at cycle 66.
REQ-038 ADC timing: same frame -> ADRst high for 4 cycles; 3 ADClk periods in CONV and 4 in SHIFT, each period 4 cycles; ADClk=0 outside CONV and SHIFT.
REQ-039 Continuous: Cont=1 from cycle 0 -> ADRst=1 the cycle after each Done; Cont dropped during frame 2 -> IDLE after frame 2's Done.
REQ-040 Overrun: Start pulses at cycles 10 and 40 -> Overrun=1 from cycle 11, Done still at cycle 65; next accepted Start clears Overrun.
REQ-041 Reset mid-OUT: Rst asserted between Clk edges -> all outputs 0 at once, no Done; Start after Rst falls runs a full 65-cycle frame.
REQ-042 CLKDIV=1 edge: single frame -> ADClk toggles every cycle in CONV and SHIFT; Done at cycle 33.

Source files
------------

// File: rtl/adc_serial_readout.sv
// Serial ADC frame controller: resets and clocks NCH serial converters, captures WIDTH bits
// per channel, then streams all channels out on a ClkOut/DataOut/FrameOut serial link.
module adc_serial_readout #(
  parameter int unsigned NCH      = 8,
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned CLKDIV   = 4,
  parameter int unsigned CONV_CYC = 16
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           Start,
  input  logic           Cont,
  input  logic [1:0]     Mode,
  output logic [1:0]     ADMode,
  output logic           ADRst,
  output logic           ADClk,
  input  logic [NCH-1:0] ADSout,
  output logic           ClkOut,
  output logic           DataOut,
  output logic           FrameOut,
  output logic           Busy,
  output logic           Done,
  output logic           Overrun
);

  localparam int unsigned NBITS = NCH * WIDTH;
  // One tick counter serves every state; OUT needs the longest run.
  localparam int unsigned TMAX  = (2 * CONV_CYC > 2 * NBITS) ? 2 * CONV_CYC : 2 * NBITS;
  localparam int unsigned TW    = $clog2(TMAX);
  localparam int unsigned DW    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  typedef enum logic [2:0] {StIdle, StAdRst, StConv, StShift, StOut} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             adclk_q, adclk_d;
  logic             fin_q, fin_d;
  logic [1:0]       mode_q, mode_d;
  logic             ovr_q, ovr_d;
  logic [NBITS-1:0] sr_q, sr_d;
  logic             tick;
  logic             frame_out;

  assign tick = (state_q != StIdle) && (div_q == DW'(CLKDIV - 1));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      tcnt_q  <= '0;
      adclk_q <= 1'b0;
      fin_q   <= 1'b0;
      mode_q  <= 2'b00;
      ovr_q   <= 1'b0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tcnt_q  <= tcnt_d;
      adclk_q <= adclk_d;
      fin_q   <= fin_d;
      mode_q  <= mode_d;
      ovr_q   <= ovr_d;
      sr_q    <= sr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = (state_q == StIdle || tick) ? '0 : div_q + DW'(1);
    tcnt_d  = tcnt_q;
    adclk_d = adclk_q;
    fin_d   = fin_q;
    mode_d  = mode_q;
    ovr_d   = ovr_q;
    sr_d    = sr_q;

    if (Start && state_q != StIdle) ovr_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          mode_d  = Mode;
          ovr_d   = 1'b0;
          state_d = StAdRst;
          div_d   = '0;
          tcnt_d  = '0;
          adclk_d = 1'b0;
        end
      end
      StAdRst: begin
        if (tick) begin
          if (tcnt_q == TW'(1)) begin
            tcnt_d  = '0;
            state_d = StConv;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      StConv: begin
        if (tick) begin
          adclk_d = ~adclk_q;
          if (tcnt_q == TW'(2 * CONV_CYC - 1)) begin
            tcnt_d  = '0;
            state_d = StShift;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      StShift: begin
        if (tick) begin
          adclk_d = ~adclk_q;
          // Sample on the falling converter clock; channel 0 occupies the top bits.
          if (adclk_q) begin
            for (int i = 0; i < NCH; i++) begin
              sr_d[(NCH-i)*WIDTH-1 -: WIDTH] = {sr_q[(NCH-i)*WIDTH-2 -: (WIDTH-1)], ADSout[i]};
            end
          end
          if (tcnt_q == TW'(2 * WIDTH - 1)) begin
            tcnt_d  = '0;
            state_d = StOut;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      StOut: begin
        if (fin_q) begin
          // Done cycle: decide between the next frame and idle.
          fin_d = 1'b0;
          div_d = '0;
          if (Cont) begin
            state_d = StAdRst;
            mode_d  = Mode;
            tcnt_d  = '0;
          end else begin
            state_d = StIdle;
          end
        end else if (tick) begin
          if (tcnt_q[0]) sr_d = sr_q << 1;
          if (tcnt_q == TW'(2 * NBITS - 1)) begin
            tcnt_d = '0;
            fin_d  = 1'b1;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign frame_out = (state_q == StOut) && !fin_q;

  assign ADMode   = mode_q;
  assign ADRst    = (state_q == StAdRst);
  assign ADClk    = adclk_q;
  assign FrameOut = frame_out;
  assign ClkOut   = frame_out && tcnt_q[0];
  assign DataOut  = frame_out && sr_q[NBITS-1];
  assign Busy     = (state_q != StIdle);
  assign Done     = (state_q == StOut) && fin_q;
  assign Overrun  = ovr_q;

endmodule

// File: tb/tb_adc_serial_readout.sv
// Scoreboard bench for adc_serial_readout: NCH=2, WIDTH=4, CONV_CYC=3 at CLKDIV=2 and CLKDIV=1.
module tb_adc_serial_readout;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, cont = 1'b0, start1 = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [1:0] adsout = 2'b00;
  logic [1:0] adsout1 = 2'b01;
  logic [1:0] admode, admode1;
  logic adrst, adclk, clkout, dataout, frameout, busy, done, overrun;
  logic adrst1, adclk1, clkout1, dataout1, frameout1, busy1, done1, overrun1;
  logic [9:0] outs, outs1;

  assign outs  = {admode, adrst, adclk, clkout, dataout, frameout, busy, done, overrun};
  assign outs1 = {admode1, adrst1, adclk1, clkout1, dataout1, frameout1, busy1, done1, overrun1};

  adc_serial_readout #(.NCH(2), .WIDTH(4), .CLKDIV(2), .CONV_CYC(3)) dut (
    .Clk(clk), .Rst(rst), .Start(start), .Cont(cont), .Mode(mode), .ADMode(admode),
    .ADRst(adrst), .ADClk(adclk), .ADSout(adsout), .ClkOut(clkout), .DataOut(dataout),
    .FrameOut(frameout), .Busy(busy), .Done(done), .Overrun(overrun)
  );

  adc_serial_readout #(.NCH(2), .WIDTH(4), .CLKDIV(1), .CONV_CYC(3)) dut1 (
    .Clk(clk), .Rst(rst), .Start(start1), .Cont(1'b0), .Mode(2'b11), .ADMode(admode1),
    .ADRst(adrst1), .ADClk(adclk1), .ADSout(adsout1), .ClkOut(clkout1), .DataOut(dataout1),
    .FrameOut(frameout1), .Busy(busy1), .Done(done1), .Overrun(overrun1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { logic [7:0] data; logic [1:0] mode; int done_cyc; } exp_t;
  typedef struct { logic [3:0] c0; logic [3:0] c1; } pat_t;
  exp_t sb_q[$];
  pat_t pat_q[$];

  // Converter model: presents the next sample after each ADClk rise in SHIFT.
  pat_t cur_pat = '{4'b0000, 4'b0000};
  int   rises = 0;
  logic d_adrst_p = 1'b0, d_adclk_p = 1'b0;
  always @(negedge clk) begin
    if (adrst && !d_adrst_p) begin
      if (pat_q.size() > 0) cur_pat = pat_q.pop_front();
      rises = 0;
    end
    if (adclk && !d_adclk_p) begin
      rises++;
      if (rises > 3 && rises <= 7) begin
        adsout[0] = cur_pat.c0[7-rises];
        adsout[1] = cur_pat.c1[7-rises];
      end
    end
    d_adrst_p = adrst;
    d_adclk_p = adclk;
  end

  // Monitor: collects serial bits and ADC timing stats, checks against scoreboard on Done.
  logic [7:0] cap = '0;
  int   ncap = 0, nrst = 0, nrise = 0, perr = 0, bad = 0, last_rise = -1;
  logic m_clkout_p = 1'b0, m_adclk_p = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (rst) begin
      cap = '0; ncap = 0; nrst = 0; nrise = 0; perr = 0; bad = 0; last_rise = -1;
    end else begin
      if (clkout && !m_clkout_p) begin
        cap = {cap[6:0], dataout};
        ncap++;
      end
      if (adrst) nrst++;
      if (adclk && !m_adclk_p) begin
        nrise++;
        if (last_rise >= 0 && cyc - last_rise != 4) perr++;
        last_rise = cyc;
      end
      if (adclk && (adrst || frameout || !busy)) bad++;
      if (done) begin
        chk("done_expected", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("frame_data", cap, e.data);
          chk("frame_admode", admode, e.mode);
          chk("done_cycle", cyc, e.done_cyc);
          chk("bits_sent", ncap, 8);
          chk("adrst_cycles", nrst, 4);
          chk("adclk_periods", nrise, 7);
          chk("adclk_period_len", perr, 0);
          chk("adclk_idle_low", bad, 0);
        end
        cap = '0; ncap = 0; nrst = 0; nrise = 0; perr = 0; bad = 0; last_rise = -1;
      end
    end
    m_clkout_p = clkout;
    m_adclk_p  = adclk;
  end

  // CLKDIV=1 instance observer.
  logic [7:0] cap1 = '0;
  int   tog1 = 0, first1 = -1, last1 = -1, done1_cyc = -1;
  logic clkout1_p = 1'b0, adclk1_p = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      cap1 = '0; tog1 = 0; first1 = -1; last1 = -1; done1_cyc = -1;
    end else begin
      if (clkout1 && !clkout1_p) cap1 = {cap1[6:0], dataout1};
      if (adclk1 != adclk1_p) begin
        tog1++;
        if (first1 < 0) first1 = cyc;
        last1 = cyc;
      end
      if (done1) done1_cyc = cyc;
    end
    clkout1_p = clkout1;
    adclk1_p  = adclk1;
  end

  task automatic issue(input logic [1:0] m, input logic [3:0] c0, input logic [3:0] c1,
                       input logic [7:0] ed, output int s);
    s     = cyc;
    mode  = m;
    start = 1'b1;
    pat_q.push_back(pat_t'{c0, c1});
    sb_q.push_back(exp_t'{ed, m, s + 65});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  int s, s1, t;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs, 0);
    chk("reset_outputs_div1", outs1, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single frame
    issue(2'b10, 4'b1010, 4'b0110, 8'b1010_0110, s);
    chk("admode_latched", admode, 2'b10);
    chk("adrst_first", adrst, 1);
    chk("busy_first", busy, 1);
    wait_to(s + 4);  chk("adrst_last", adrst, 1);
    wait_to(s + 5);  chk("adrst_released", adrst, 0);
    wait_to(s + 64); chk("no_early_done", done, 0);
    wait_to(s + 66); chk("idle_after_done", busy, 0);
    chk("done_one_cycle", done, 0);

    // Overrun
    issue(2'b01, 4'b1100, 4'b0011, 8'b1100_0011, s);
    wait_to(s + 10); chk("overrun_before", overrun, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("overrun_set", overrun, 1);
    wait_to(s + 40);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_to(s + 66);
    chk("overrun_sticky", overrun, 1);
    chk("overrun_idle", busy, 0);

    // Continuous: two frames, mode changed during frame 1, Cont dropped in frame 2
    cont = 1'b1;
    issue(2'b11, 4'b0111, 4'b1000, 8'b0111_1000, s);
    chk("overrun_cleared", overrun, 0);
    pat_q.push_back(pat_t'{4'b1001, 4'b0101});
    sb_q.push_back(exp_t'{8'b1001_0101, 2'b00, s + 130});
    wait_to(s + 30);  mode = 2'b00;
    wait_to(s + 65);  chk("cont_busy_at_done", busy, 1);
    wait_to(s + 66);  chk("cont_adrst_after_done", adrst, 1);
    chk("cont_mode_relatched", admode, 2'b00);
    wait_to(s + 100); cont = 1'b0;
    wait_to(s + 131); chk("cont_stop_idle", busy, 0);
    wait_to(s + 140); chk("cont_no_third", busy, 0);

    // Cont alone in idle does nothing
    cont = 1'b1;
    repeat (5) @(negedge clk);
    chk("cont_idle_busy", busy, 0);
    chk("cont_idle_adrst", adrst, 0);
    cont = 1'b0;

    // Reset mid-OUT
    issue(2'b10, 4'b0101, 4'b1110, 8'b0101_1110, s);
    wait_to(s + 45);
    chk("in_out_state", frameout, 1);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", outs, 0);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    t = cyc + 70;
    wait_to(t);
    chk("abort_stays_idle", busy, 0);
    issue(2'b01, 4'b1111, 4'b0001, 8'b1111_0001, s);
    wait_to(s + 66);
    chk("post_reset_idle", busy, 0);

    // CLKDIV=1 instance
    s1 = cyc;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    while (done1_cyc < 0 && cyc < s1 + 60) @(negedge clk);
    chk("div1_done_cycle", done1_cyc - s1, 33);
    chk("div1_data", cap1, 8'hF0);
    chk("div1_toggles", tog1, 14);
    chk("div1_toggle_span", last1 - first1, 13);
    @(negedge clk);
    chk("div1_idle", busy1, 0);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
